// File: rtl/seq_div64_if.sv
// rtl/seq_div64_if.sv - request/result bundle between the execute stage and seq_div64
// Purpose: groups the divider's start/operand request and its result signals.
// Signals:
//   start       request, accepted only when the divider is idle
//   is_signed   1 = DIV/REM, 0 = DIVU/REMU; sampled with start
//   a, b        dividend / divisor, sampled with start
//   busy        divider occupied (every non-idle cycle, including the done cycle)
//   done        one-cycle pulse; results valid in that cycle
//   quotient    result, held until the next accepted start
//   remainder   result, held until the next accepted start
//   div_by_zero set with done when b == 0; held like the results
// Modports: master = execute stage, slave = divider.
interface seq_div64_if;
  logic        start;
  logic        is_signed;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div64.sv
// rtl/seq_div64.sv - multi-cycle 64-bit RISC-V DIV/DIVU/REM/REMU unit on one shared subtractor
// Purpose: restoring divider, one subtract/compare per cycle through a single sub64.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  seq_div64_if.slave (start/is_signed/a/b in; busy/done/quotient/remainder/div_by_zero out)
// Optional feature macro: SEQ_DIV64_EARLY_OUT_EN
//   When defined, an unsigned request with a < b finishes in one cycle
//   (quotient = 0, remainder = a) using an IDLE compare leg on sub64.

// Shared subtractor: diff = x - y, c_out = 1 when no borrow (x >= y unsigned).
module sub64 (
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [63:0] diff,
  output logic        c_out
);
  assign {c_out, diff} = {1'b0, x} + {1'b0, ~y} + 65'd1;
endmodule

module seq_div64 #(
  parameter int XLEN  = 64,
  parameter int ITERS = 64
) (
  input  logic        clk,
  input  logic        rst,
  seq_div64_if.slave  bus
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [2:0] {
    S_IDLE, S_ZERO, S_ABS_A, S_ABS_B, S_ITER, S_FIX_Q, S_FIX_R, S_DONE
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0] q;        // dividend magnitude, shifts into quotient
  logic [XLEN-1:0] r;        // partial remainder
  logic [XLEN-1:0] d;        // divisor magnitude
  logic [CW-1:0]   cnt;
  logic            neg_a;    // signed op with negative dividend
  logic            neg_b;    // signed op with negative divisor
  logic            neg_q;    // quotient must be negated at the end

  logic [XLEN-1:0] quotient_r;
  logic [XLEN-1:0] remainder_r;
  logic            dbz_r;

  logic [XLEN-1:0] sub_x, sub_y, sub_d;
  logic            sub_c;

  logic [XLEN-1:0] p;
  logic            t;
  logic            accept;
  logic            last_iter;
  logic            early_hit;
  logic            b_zero;

  // Shift step: the bit leaving R becomes a 65th bit of P; if set, P > D always.
  assign p         = {r[XLEN-2:0], q[XLEN-1]};
  assign t         = r[XLEN-1];
  assign accept    = t | sub_c;
  assign last_iter = (cnt == CW'(ITERS - 1));
  assign b_zero    = (bus.b == '0);

`ifdef SEQ_DIV64_EARLY_OUT_EN
  // Unsigned a < b: the quotient is trivially zero, skip the iterations.
  assign early_hit = ~bus.is_signed & ~sub_c;
`else
  assign early_hit = 1'b0;
`endif

  // Operand mux for the single subtractor. Negations are 0 - x (sub_x stays 0).
  always_comb begin
    sub_x = '0;
    sub_y = '0;
    case (state)
`ifdef SEQ_DIV64_EARLY_OUT_EN
      S_IDLE: begin
        sub_x = bus.a;
        sub_y = bus.b;
      end
`endif
      S_ABS_A: sub_y = q;
      S_ABS_B: sub_y = d;
      S_ITER: begin
        sub_x = p;
        sub_y = d;
      end
      S_FIX_Q: sub_y = q;
      S_FIX_R: sub_y = r;
      default: ;
    endcase
  end

  sub64 u_sub (
    .x     (sub_x),
    .y     (sub_y),
    .diff  (sub_d),
    .c_out (sub_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (state)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (b_zero)         state_n = S_ZERO;
          else if (early_hit) state_n = S_DONE;
          else                state_n = S_ABS_A;
        end
      end
      S_ZERO: begin
        bus.done = 1'b1;
        state_n  = S_IDLE;
      end
      S_ABS_A: state_n = S_ABS_B;
      S_ABS_B: state_n = S_ITER;
      S_ITER:  if (last_iter) state_n = S_FIX_Q;
      S_FIX_Q: state_n = S_FIX_R;
      S_FIX_R: state_n = S_DONE;
      S_DONE: begin
        bus.done = 1'b1;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      neg_q       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            neg_a <= bus.is_signed & bus.a[XLEN-1];
            neg_b <= bus.is_signed & bus.b[XLEN-1];
            neg_q <= bus.is_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            q     <= bus.a;
            d     <= bus.b;
            r     <= '0;
            cnt   <= '0;
            dbz_r <= b_zero;
            // Short paths publish their results at acceptance so they are
            // visible in the following done cycle.
            if (b_zero) begin
              quotient_r  <= '1;
              remainder_r <= bus.a;
            end else if (early_hit) begin
              quotient_r  <= '0;
              remainder_r <= bus.a;
            end
          end
        end
        S_ABS_A: if (neg_a) q <= sub_d;
        S_ABS_B: begin
          if (neg_b) d <= sub_d;
          cnt <= '0;
        end
        S_ITER: begin
          r   <= accept ? sub_d : p;
          q   <= {q[XLEN-2:0], accept};
          cnt <= cnt + 1'b1;
        end
        S_FIX_Q: if (neg_q) q <= sub_d;
        S_FIX_R: begin
          // Remainder sign follows the dividend.
          r           <= neg_a ? sub_d : r;
          quotient_r  <= q;
          remainder_r <= neg_a ? sub_d : r;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_div64.sv
// tb/tb_seq_div64.sv - self-checking bench for seq_div64 with a result scoreboard
module tb_seq_div64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_div64_if dif();

  seq_div64 dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Index of the done sample, counted from the first sample after the accepting edge.
  function automatic int exp_lat(input logic [63:0] a, input logic [63:0] b, input logic sgn);
    if (b == 64'd0) return 0;
`ifdef SEQ_DIV64_EARLY_OUT_EN
    if (!sgn && (a < b)) return 0;
`else
    if (sgn && a[0] && !a[0]) return 0;
`endif
    return 68;
  endfunction

  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       output logic [63:0] eq, output logic [63:0] er);
    logic signed [63:0] sa, sb_;
    sa  = a;
    sb_ = b;
    if (sgn) begin
      eq = sa / sb_;
      er = sa % sb_;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sgn, input logic [63:0] eq, input logic [63:0] er,
                        input logic edbz);
    exp_t e, g;
    int   idx;
    bit   got;
    e.q = eq; e.r = er; e.dbz = edbz; e.lat = exp_lat(a, b, sgn);
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b1; dif.a = a; dif.b = b; dif.is_signed = sgn;
    @(posedge clk); #1;
    dif.start = 1'b0;
    idx = 0; got = 1'b0;
    while (!got && idx < 150) begin
      if (dif.done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        idx++;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      g = sb.pop_front();
      check({tag, "_q"},    dif.quotient,         g.q);
      check({tag, "_r"},    dif.remainder,        g.r);
      check({tag, "_dbz"},  64'(dif.div_by_zero), 64'(g.dbz));
      check({tag, "_lat"},  64'(idx),             64'(g.lat));
      check({tag, "_busy"}, 64'(dif.busy),        64'd1);
      @(posedge clk); #1;
      check({tag, "_done_drop"}, 64'(dif.done), 64'd0);
      check({tag, "_busy_drop"}, 64'(dif.busy), 64'd0);
      check({tag, "_q_hold"},    dif.quotient,  g.q);
    end
  endtask

  initial begin
    logic [63:0] ra, rb, eq, er;
    exp_t g;
    int   n_done;

    dif.start = 1'b0; dif.is_signed = 1'b0; dif.a = '0; dif.b = '0;
    #12;
    check("rst_busy", 64'(dif.busy),        64'd0);
    check("rst_done", 64'(dif.done),        64'd0);
    check("rst_q",    dif.quotient,         64'd0);
    check("rst_r",    dif.remainder,        64'd0);
    check("rst_dbz",  64'(dif.div_by_zero), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run_op("udiv",    64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0);
    run_op("sdiv",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0);
    run_op("sdiv_nb", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
    run_op("sdiv_nn", 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
           64'd3, ONES, 1'b0);
    run_op("dz_u",    64'd5, 64'd0, 1'b0, ONES, 64'd5, 1'b1);
    run_op("dz_s",    64'd5, 64'd0, 1'b1, ONES, 64'd5, 1'b1);
    run_op("ovf",     MIN, ONES, 1'b1, MIN, 64'd0, 1'b0);
    run_op("small_u", 64'd3, 64'd10, 1'b0, 64'd0, 64'd3, 1'b0);
    run_op("small_s", 64'd3, 64'd10, 1'b1, 64'd0, 64'd3, 1'b0);
    run_op("umax",    ONES, 64'd1, 1'b0, ONES, 64'd0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (rb == 64'd0) rb = 64'd1;
      if (ra == MIN && rb == ONES) rb = 64'd3;
      model(ra, rb, i[0], eq, er);
      run_op($sformatf("rnd%0d", i), ra, rb, i[0], eq, er, 1'b0);
    end

    // Second start while busy must be ignored.
    g.q = 64'd100; g.r = 64'd0; g.dbz = 1'b0; g.lat = 68;
    sb.push_back(g);
    @(negedge clk);
    dif.start = 1'b1; dif.a = 64'd1000; dif.b = 64'd10; dif.is_signed = 1'b0;
    @(posedge clk); #1;
    dif.start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 150; i++) begin
      if (i == 19) begin
        dif.start = 1'b1; dif.a = 64'd9; dif.b = 64'd3;
      end
      if (i == 20) dif.start = 1'b0;
      if (dif.done) begin
        n_done++;
        if (n_done == 1) begin
          g = sb.pop_front();
          check("busy_q",   dif.quotient,  g.q);
          check("busy_r",   dif.remainder, g.r);
          check("busy_lat", 64'(i),        64'(g.lat));
        end
      end
      @(posedge clk); #1;
    end
    check("busy_single_done", 64'(n_done), 64'd1);
    check("busy_q_final",     dif.quotient, 64'd100);

    // Reset mid-operation aborts with no done pulse.
    @(negedge clk);
    dif.start = 1'b1; dif.a = 64'd1000; dif.b = 64'd10; dif.is_signed = 1'b0;
    @(posedge clk); #1;
    dif.start = 1'b0;
    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(dif.busy),        64'd0);
    check("mid_rst_done", 64'(dif.done),        64'd0);
    check("mid_rst_q",    dif.quotient,         64'd0);
    check("mid_rst_r",    dif.remainder,        64'd0);
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (dif.done) n_done++;
    end
    check("mid_rst_no_done", 64'(n_done), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
